fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences one 32-point frame through the five MAC butterfly stages (16 MACs each).
//  Accepts a frame via valid/ready, then steps the stages in order, driving per-stage
//  PU_enable, the shared 3-bit MAC sel and the twiddle stride.
//  Presents out_valid until the downstream consumer takes the result.
//  Sits between the input frame buffer and the FFT_Stage1..5 datapath.
// PARAMETERS
//  NUM_STAGES  5  butterfly stages per frame (log2 of 32)
//  MAC_CYCLES  4  cycles per stage; sel counts 0..MAC_CYCLES-1; legal range 1..8
//  SEL_WIDTH   3  width of MAC sel bus
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           synchronous, active-low reset
//  clear      in   1           synchronous abort; returns to IDLE
//  in_valid   in   1           upstream frame ready
//  in_ready   out  1           sequencer can accept a frame
//  load_en    out  1           one-cycle pulse: capture input frame into Stage1 regs
//  pu_enable  out  NUM_STAGES  one-hot stage enable (bit s -> Stage s+1 PU_enable)
//  sel        out  SEL_WIDTH   MAC sub-cycle select, shared by all stages
//  tw_stride  out  3           log2 twiddle stride for active stage (= stage index)
//  busy       out  1           high in LOAD and RUN
//  out_valid  out  1           frame result stable on Stage5 outputs
//  out_ready  in   1           downstream accepts result
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; stage=0, sel=0, pu_enable=0, tw_stride=0,
//   load_en=0, busy=0, out_valid=0; in_ready=1 from the first cycle after reset releases.
//  FSM states IDLE, LOAD, RUN, DONE:
//   IDLE: in_ready=1; in_valid&&in_ready -> LOAD.
//   LOAD: load_en=1, busy=1 for exactly one cycle -> RUN with stage=0, sel=0.
//   RUN: pu_enable=1<<stage, tw_stride=stage, busy=1; sel increments every cycle;
//    sel==MAC_CYCLES-1: sel->0, stage++; at stage==NUM_STAGES-1 -> DONE instead.
//   DONE: out_valid=1, pu_enable=0, busy=0; out_ready -> IDLE (same edge).
//  Latency: accept edge to out_valid = 1 + NUM_STAGES*MAC_CYCLES cycles (21 at defaults).
//  in_ready=0 outside IDLE; in_valid there is ignored, not queued.
//  out_ready high before DONE: DONE lasts exactly one cycle.
//  out_ready low: hold DONE and all outputs indefinitely.
//  MAC_CYCLES==1: sel stays 0; each stage occupies one cycle.
//  clear (when reset==1): next state IDLE, outputs at reset values; clear wins over
//   in_valid and out_ready in the same cycle. reset has priority over clear.
//  Outputs registered; no combinational in->out path except none (in_ready from state).
// CONFIGURATION
//  FFT_SEQ_PERF_CNT_EN defined: extra outputs frame_cnt[15:0] (increments on each
//   DONE->IDLE handoff, wraps 0xFFFF->0) and stall_cnt[15:0] (cycles in DONE with
//   out_ready==0, saturates at 0xFFFF); both cleared by reset, not by clear.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package fft_pkg: state enum {IDLE,LOAD,RUN,DONE}, FFT_POINTS=32,
//   FFT_STAGES=5, MACS_PER_STAGE=16.
//  One sub-module fft_seq_counter: stage/sel nested counter with wrap and last flag;
//   FSM and handshake stay in the top.
// TESTING
//  Single frame, out_ready=1: in_valid pulse -> load_en at +1, pu_enable 00001..10000
//   each 4 cycles, sel 0,1,2,3 repeated, out_valid at +21 for 1 cycle.
//  Backpressure: out_ready=0 for 10 cycles at DONE -> out_valid held, sel/pu stable;
//   in_ready=0 throughout; release -> IDLE next cycle, in_ready=1.
//  in_valid held high continuously -> back-to-back frames, accepts spaced 23 cycles.
//  clear asserted in RUN stage 2, sel 1 -> next cycle IDLE, pu_enable=0, busy=0.
//  reset low mid-RUN -> all outputs reset values next edge; reset+clear together -> reset.
//  MAC_CYCLES=1 build: latency 6, sel constant 0; PERF_CNT build: 3 frames -> frame_cnt=3.

Source files
------------

// File: rtl/fft_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fft_pkg
//  Description : Shared types and constants for the 32-point FFT stage
//                sequencer: FSM state encoding, frame geometry and the width
//                of the twiddle-stride / stage-index bus.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

  // Frame geometry: 32 points -> log2(32) = 5 radix-2 stages of 16 MACs.
  localparam int FFT_POINTS     = 32;
  localparam int FFT_STAGES     = 5;
  localparam int MACS_PER_STAGE = FFT_POINTS / 2;

  // Stage index doubles as log2 twiddle stride; 3 bits cover up to 8 stages.
  localparam int TW_WIDTH = 3;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fft_stage_sequencer_if
//  Description : Frame handshake and stage-control bus of the FFT stage
//                sequencer.
//                master : sequencer side (drives stage controls, in_ready,
//                         out_valid; receives in_valid, out_ready)
//                slave  : upstream buffer / datapath / downstream side
//  Signals     : in_valid, in_ready   frame accept handshake
//                load_en              Stage1 capture pulse
//                pu_enable            one-hot stage enable
//                sel                  shared MAC sub-cycle select
//                tw_stride            log2 twiddle stride of active stage
//                busy                 LOAD or RUN in progress
//                out_valid, out_ready result handoff handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_stage_sequencer_if
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = FFT_STAGES,
  parameter int SEL_WIDTH  = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  load_en;
  logic [NUM_STAGES-1:0] pu_enable;
  logic [SEL_WIDTH-1:0]  sel;
  logic [TW_WIDTH-1:0]   tw_stride;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output load_en,
    output pu_enable,
    output sel,
    output tw_stride,
    output busy,
    output out_valid
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  load_en,
    input  pu_enable,
    input  sel,
    input  tw_stride,
    input  busy,
    input  out_valid
  );

endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fft_seq_counter
//  Description : Nested stage/sel counter. sel counts 0..MAC_CYCLES-1 while
//                adv_i is high; on sel wrap the stage index advances. After
//                the last sel of the last stage both fields return to zero,
//                so the counter is always at 0/0 whenever a run begins.
//  Ports       : clk        in   clock, rising edge
//                reset      in   synchronous active-low reset
//                clr_i      in   synchronous clear to 0/0 (abort)
//                adv_i      in   advance one MAC sub-cycle
//                stage_o    out  current stage index (registered)
//                sel_o      out  current MAC sub-cycle (registered)
//                sel_wrap_o out  sel is on its final sub-cycle
//                last_o     out  final sub-cycle of the final stage
//  Revision    : 1.0  initial release
// ============================================================================
module fft_seq_counter
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = FFT_STAGES,
  parameter int MAC_CYCLES = 4,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 adv_i,
  output logic [TW_WIDTH-1:0]  stage_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 sel_wrap_o,
  output logic                 last_o
);

  localparam logic [SEL_WIDTH-1:0] SEL_LAST   = SEL_WIDTH'(MAC_CYCLES - 1);
  localparam logic [TW_WIDTH-1:0]  STAGE_LAST = TW_WIDTH'(NUM_STAGES - 1);

  logic [TW_WIDTH-1:0]  stage_q, stage_d;
  logic [SEL_WIDTH-1:0] sel_q,   sel_d;

  // With MAC_CYCLES==1 SEL_LAST is 0, so every cycle is a wrap and sel
  // never leaves zero.
  assign sel_wrap_o = (sel_q == SEL_LAST);
  assign last_o     = sel_wrap_o && (stage_q == STAGE_LAST);

  always_comb begin
    stage_d = stage_q;
    sel_d   = sel_q;
    if (clr_i) begin
      stage_d = '0;
      sel_d   = '0;
    end else if (adv_i) begin
      if (!sel_wrap_o) begin
        sel_d = sel_q + SEL_WIDTH'(1);
      end else begin
        sel_d   = '0;
        stage_d = last_o ? '0 : stage_q + TW_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
      sel_q   <= '0;
    end else begin
      stage_q <= stage_d;
      sel_q   <= sel_d;
    end
  end

  assign stage_o = stage_q;
  assign sel_o   = sel_q;

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_sequencer
//  Description : Sequences one 32-point frame through the butterfly stages.
//                IDLE accepts a frame, LOAD pulses load_en for one cycle,
//                RUN walks every stage for MAC_CYCLES cycles with a one-hot
//                pu_enable, DONE holds out_valid until out_ready.
//                Accept edge to out_valid is 1 + NUM_STAGES*MAC_CYCLES cycles.
//  Ports       : clk          in   clock, rising edge
//                reset        in   synchronous active-low reset (beats clear)
//                clear_i      in   synchronous abort back to IDLE
//                frame_cnt_o  out  completed frames (FFT_SEQ_PERF_CNT_EN only)
//                stall_cnt_o  out  DONE backpressure cycles (FFT_SEQ_PERF_CNT_EN
//                                  only)
//                bus          --   fft_stage_sequencer_if.master
//  Config      : `define FFT_SEQ_PERF_CNT_EN adds the frame/stall counters.
//                Default build omits them.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = FFT_STAGES,
  parameter int MAC_CYCLES = 4,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
`ifdef FFT_SEQ_PERF_CNT_EN
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           stall_cnt_o,
`endif
  fft_stage_sequencer_if.master bus
);

  seq_state_e            state_q;
  logic                  load_en_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [NUM_STAGES-1:0] pu_enable_q;

  logic [TW_WIDTH-1:0]   stage_w;
  logic [SEL_WIDTH-1:0]  sel_w;
  logic                  sel_wrap_w;
  logic                  last_w;
  logic                  run_w;

  assign run_w = (state_q == RUN);

  fft_seq_counter #(
    .NUM_STAGES (NUM_STAGES),
    .MAC_CYCLES (MAC_CYCLES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clear_i),
    .adv_i      (run_w),
    .stage_o    (stage_w),
    .sel_o      (sel_w),
    .sel_wrap_o (sel_wrap_w),
    .last_o     (last_w)
  );

  // Control FSM; every stage-control output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      state_q     <= IDLE;
      load_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      pu_enable_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q   <= LOAD;
            load_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q     <= RUN;
          load_en_q   <= 1'b0;
          pu_enable_q <= NUM_STAGES'(1);
        end
        RUN: begin
          if (last_w) begin
            state_q     <= DONE;
            pu_enable_q <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (sel_wrap_w) begin
            pu_enable_q <= pu_enable_q << 1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // in_ready is a pure decode of the state register, so it never depends
  // combinationally on in_valid.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.load_en   = load_en_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pu_enable = pu_enable_q;
  // Counter sits at 0/0 outside RUN, so sel and tw_stride read zero there.
  assign bus.sel       = sel_w;
  assign bus.tw_stride = stage_w;

`ifdef FFT_SEQ_PERF_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] stall_cnt_q;

  // Statistics survive clear; only reset zeroes them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == DONE) begin
      // An abort out of DONE is not a delivered frame.
      if (bus.out_ready && !clear_i) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (!bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_stage_sequencer
//  Description : Directed self-checking bench for fft_stage_sequencer.
//                dut0 uses the default build (MAC_CYCLES=4), dut1 uses
//                MAC_CYCLES=1. Counter checks apply when
//                FFT_SEQ_PERF_CNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_stage_sequencer;

  logic clk;
  logic reset;
  logic clear;

  int tests_run    = 0;
  int tests_failed = 0;

  fft_stage_sequencer_if #(.NUM_STAGES(5), .SEL_WIDTH(3)) bus0 ();
  fft_stage_sequencer_if #(.NUM_STAGES(5), .SEL_WIDTH(3)) bus1 ();

`ifdef FFT_SEQ_PERF_CNT_EN
  logic [15:0] frame_cnt0, stall_cnt0, frame_cnt1, stall_cnt1;
`endif

  fft_stage_sequencer #(.NUM_STAGES(5), .MAC_CYCLES(4), .SEL_WIDTH(3)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
`ifdef FFT_SEQ_PERF_CNT_EN
    .frame_cnt_o (frame_cnt0),
    .stall_cnt_o (stall_cnt0),
`endif
    .bus         (bus0)
  );

  fft_stage_sequencer #(.NUM_STAGES(5), .MAC_CYCLES(1), .SEL_WIDTH(3)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
`ifdef FFT_SEQ_PERF_CNT_EN
    .frame_cnt_o (frame_cnt1),
    .stall_cnt_o (stall_cnt1),
`endif
    .bus         (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle0(input string tag);
    check_val({tag, "_in_ready"},  32'(bus0.in_ready),  32'd1);
    check_val({tag, "_pu"},        32'(bus0.pu_enable), 32'd0);
    check_val({tag, "_sel"},       32'(bus0.sel),       32'd0);
    check_val({tag, "_tw"},        32'(bus0.tw_stride), 32'd0);
    check_val({tag, "_busy"},      32'(bus0.busy),      32'd0);
    check_val({tag, "_out_valid"}, 32'(bus0.out_valid), 32'd0);
    check_val({tag, "_load_en"},   32'(bus0.load_en),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b0;
    clear          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_idle0("rst");
    reset = 1'b1;
    tick();
    check_val("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);

    // ---------------- single frame, out_ready=1 ----------------
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    check_val("f1_load_en", 32'(bus0.load_en),  32'd1);
    check_val("f1_busy",    32'(bus0.busy),     32'd1);
    check_val("f1_in_rdy",  32'(bus0.in_ready), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_val($sformatf("f1_pu_%0d", k),  32'(bus0.pu_enable), 32'(1 << (k / 4)));
      check_val($sformatf("f1_sel_%0d", k), 32'(bus0.sel),       32'(k % 4));
      check_val($sformatf("f1_tw_%0d", k),  32'(bus0.tw_stride), 32'(k / 4));
      if (k == 0) begin
        check_val("f1_load_en_drop", 32'(bus0.load_en), 32'd0);
        check_val("f1_busy_run",     32'(bus0.busy),    32'd1);
      end
    end
    tick();
    check_val("f1_out_valid", 32'(bus0.out_valid), 32'd1);
    check_val("f1_done_pu",   32'(bus0.pu_enable), 32'd0);
    check_val("f1_done_busy", 32'(bus0.busy),      32'd0);
    tick();
    check_val("f1_ov_1cyc",   32'(bus0.out_valid), 32'd0);
    check_val("f1_idle_rdy",  32'(bus0.in_ready),  32'd1);

    // ---------------- backpressure at DONE ----------------
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    tick();
    bus0.in_valid  = 1'b0;
    repeat (20) tick();
    tick();
    check_val("bp_out_valid", 32'(bus0.out_valid), 32'd1);
    bus0.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val($sformatf("bp_hold_ov_%0d", i),  32'(bus0.out_valid), 32'd1);
      check_val($sformatf("bp_hold_pu_%0d", i),  32'(bus0.pu_enable), 32'd0);
      check_val($sformatf("bp_hold_sel_%0d", i), 32'(bus0.sel),       32'd0);
      check_val($sformatf("bp_hold_rdy_%0d", i), 32'(bus0.in_ready),  32'd0);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    check_val("bp_release_rdy", 32'(bus0.in_ready),  32'd1);
    check_val("bp_release_ov",  32'(bus0.out_valid), 32'd0);
    tick();
    check_val("bp_not_queued",  32'(bus0.load_en),   32'd0);

    // ---------------- back-to-back frames ----------------
    bus0.in_valid = 1'b1;
    tick();
    check_val("b2b_accept1", 32'(bus0.load_en), 32'd1);
    for (int f = 0; f < 2; f++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus0.load_en && n < 100);
      check_val($sformatf("b2b_spacing_%0d", f), 32'(n), 32'd23);
    end
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.in_ready && n < 100) begin
      tick();
      n++;
    end
    check_val("b2b_drain", 32'(n), 32'd22);
`ifdef FFT_SEQ_PERF_CNT_EN
    check_val("perf_frames", 32'(frame_cnt0), 32'd5);
    check_val("perf_stalls", 32'(stall_cnt0), 32'd10);
`endif

    // ---------------- clear in RUN stage 2, sel 1 ----------------
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    repeat (10) tick();
    check_val("clr_pre_sel", 32'(bus0.sel),       32'd1);
    check_val("clr_pre_pu",  32'(bus0.pu_enable), 32'b00100);
    check_val("clr_pre_tw",  32'(bus0.tw_stride), 32'd2);
    clear         = 1'b1;
    bus0.in_valid = 1'b1;
    tick();
    check_idle0("clr");
    clear         = 1'b0;
    bus0.in_valid = 1'b0;
`ifdef FFT_SEQ_PERF_CNT_EN
    check_val("perf_clr_keeps", 32'(frame_cnt0), 32'd5);
`endif

    // ---------------- reset (with clear) mid-RUN ----------------
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    repeat (6) tick();
    check_val("rr_busy_pre", 32'(bus0.busy), 32'd1);
    reset = 1'b0;
    clear = 1'b1;
    tick();
    check_idle0("rr");
`ifdef FFT_SEQ_PERF_CNT_EN
    check_val("perf_rst_frames", 32'(frame_cnt0), 32'd0);
    check_val("perf_rst_stalls", 32'(stall_cnt0), 32'd0);
`endif
    reset = 1'b1;
    clear = 1'b0;
    tick();
    check_val("rr_post_rdy", 32'(bus0.in_ready), 32'd1);

    // ---------------- MAC_CYCLES=1 instance ----------------
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check_val("m1_load_en", 32'(bus1.load_en), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val($sformatf("m1_pu_%0d", k),  32'(bus1.pu_enable), 32'(1 << k));
      check_val($sformatf("m1_sel_%0d", k), 32'(bus1.sel),       32'd0);
      check_val($sformatf("m1_tw_%0d", k),  32'(bus1.tw_stride), 32'(k));
    end
    tick();
    check_val("m1_out_valid", 32'(bus1.out_valid), 32'd1);
    tick();
    check_val("m1_idle_rdy",  32'(bus1.in_ready),  32'd1);
`ifdef FFT_SEQ_PERF_CNT_EN
    check_val("m1_perf_frames", 32'(frame_cnt1), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
